weight_readback_axis: RTL and testbench

AXI-Stream master that reads a contiguous range of the weight memory and streams it out word by word. It is the transmit counterpart of the weight loader, which accepts an AXI-Stream and drives weight_wr_data/addr/en. Used for host readback and checksum of loaded kernels, biases and macc_coeff. It sits beside the weight memory on its read port, and its output feeds the outbound DMA stream.

---
 rtl/weight_pkg.sv | 15 +
 rtl/weight_readback_fifo.sv | 64 ++++++
 rtl/weight_readback_axis.sv | 143 ++++++++++++++
 tb/tb_weight_readback_axis.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared constants and FSM encoding for the weight memory loader and readback paths.
package weight_pkg;

    localparam int unsigned WEIGHT_LIMIT = 99678;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W       = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/weight_readback_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head word and its valid flag come straight from registers.
module weight_readback_fifo
    import weight_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_W + 1,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && (r_count != CNT_W'(DEPTH));

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/weight_readback_axis.sv
// Streams a clamped, contiguous range of weight memory out as an AXI-Stream.
// Reads are credit-limited so the output FIFO can never overflow.
module weight_readback_axis
    import weight_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_weight_rd_en,
    output logic [ADDR_W-1:0] o_weight_rd_addr,
    input  logic [DATA_W-1:0] i_weight_rd_data,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    input  logic              i_m_axis_tready,
    output logic              o_m_axis_tlast
);

    localparam int unsigned       CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(WEIGHT_LIMIT);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_base_addr;
    logic [ADDR_W-1:0] r_eff_len;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_err;

    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_req_len;
    logic              w_req_err;
    logic              w_start_ok;
    logic              w_credit;
    logic              w_rd_en;
    logic              w_last_rd;
    logic              w_beat;
    logic              w_fifo_valid;
    logic [DATA_W:0]   w_fifo_dout;
    logic [CNT_W-1:0]  w_fifo_count;

    // Range clamp; the sum is one bit wider so it cannot wrap.
    assign w_sum = {1'b0, i_start_addr} + {1'b0, i_length};

    always_comb begin
        w_req_len = i_length;
        w_req_err = 1'b0;
        if (i_start_addr >= LIMIT) begin
            w_req_len = '0;
            w_req_err = 1'b1;
        end else if (w_sum > {1'b0, LIMIT}) begin
            w_req_len = LIMIT - i_start_addr;
            w_req_err = 1'b1;
        end
    end

    assign w_start_ok = i_start && (r_state == StIdle);
    assign w_credit   = ({1'b0, w_fifo_count} + (CNT_W + 1)'(r_inflight))
                        < (CNT_W + 1)'(FIFO_DEPTH);
    assign w_rd_en    = (r_state == StRun) && w_credit;
    assign w_last_rd  = (r_rd_cnt == r_eff_len - ADDR_W'(1));
    assign w_beat     = w_fifo_valid && i_m_axis_tready;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_state_d = (w_req_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_rd_en && w_last_rd) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_beat && w_fifo_dout[DATA_W]) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_base_addr     <= '0;
            r_eff_len       <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en && w_last_rd;
            if (w_start_ok) begin
                r_base_addr <= i_start_addr;
                r_eff_len   <= w_req_len;
                r_rd_cnt    <= '0;
                r_err       <= w_req_err;
            end else if (w_rd_en) begin
                r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            end
        end
    end

    // tlast rides in the top bit of each FIFO word.
    weight_readback_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, i_weight_rd_data}),
        .i_pop   (i_m_axis_tready),
        .o_data  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign o_busy           = (r_state == StRun) || (r_state == StDrain);
    assign o_done           = (r_state == StDone);
    assign o_err            = r_err;
    assign o_weight_rd_en   = w_rd_en;
    assign o_weight_rd_addr = w_rd_en ? (r_base_addr + r_rd_cnt) : '0;
    assign o_m_axis_tvalid  = w_fifo_valid;
    assign o_m_axis_tdata   = w_fifo_valid ? w_fifo_dout[DATA_W-1:0] : '0;
    assign o_m_axis_tlast   = w_fifo_valid && w_fifo_dout[DATA_W];

endmodule

// File: tb/tb_weight_readback_axis.sv
// Directed bench: expected reads and beats are queued at each start and
// checked as the DUT issues reads and completes handshakes.
module tb_weight_readback_axis;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [31:0] LIMIT      = 32'd99678;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic [31:0] length;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    int n_checks = 0;
    int n_fail   = 0;
    int issued   = 0;
    int beats    = 0;
    int cyc;
    int b0;

    logic [31:0] rd_q[$];
    logic [32:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat  = '0;

    weight_readback_axis #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_start          (start),
        .i_start_addr     (start_addr),
        .i_length         (length),
        .o_busy           (busy),
        .o_done           (done),
        .o_err            (err),
        .o_weight_rd_en   (rd_en),
        .o_weight_rd_addr (rd_addr),
        .i_weight_rd_data (rd_data),
        .o_m_axis_tdata   (tdata),
        .o_m_axis_tvalid  (tvalid),
        .i_m_axis_tready  (tready),
        .o_m_axis_tlast   (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds i+100, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) rd_data <= rd_addr + 32'd100;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            issued     = 0;
            beats      = 0;
        end else begin
            if (prev_stall) chk("stall_hold", {tvalid, tlast, tdata}, {1'b1, prev_beat});
            if (rd_en) begin
                issued++;
                chk("rd_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) chk("rd_addr", rd_addr, rd_q.pop_front());
            end
            if (tvalid && tready) begin
                beats++;
                chk("beat_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("beat", {tlast, tdata}, exp_q.pop_front());
            end
            if (rd_en) chk("outstanding", 64'((issued - beats) <= int'(FIFO_DEPTH)), 1);
            prev_stall = tvalid && !tready;
            prev_beat  = {tlast, tdata};
        end
    end

    task automatic do_start(input logic [31:0] a, input logic [31:0] n, input int eff);
        start      = 1'b1;
        start_addr = a;
        length     = n;
        for (int i = 0; i < eff; i++) begin
            rd_q.push_back(a + 32'(i));
            exp_q.push_back({(i == eff - 1), a + 32'(i) + 32'd100});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit rnd, output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
            if (rnd) tready = 1'($urandom_range(0, 1));
        end while (!done && c < 300);
        chk("done_seen", done, 1);
        chk("done_busy", busy, 0);
        chk("beats_left", exp_q.size(), 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        tready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_outputs", {busy, done, err, rd_en, tvalid, tlast}, 0);
        chk("rst_data", {rd_addr, tdata}, 0);

        // Basic run, tready high: timing and no bubbles.
        do_start(32'd0, 32'd4, 4);
        chk("t1_busy", busy, 1);
        chk("t1_rd0", {rd_en, rd_addr}, {1'b1, 32'd0});
        chk("t1_nvalid0", tvalid, 0);
        idle_cycle();
        chk("t1_rd1", {rd_en, rd_addr}, {1'b1, 32'd1});
        chk("t1_nvalid1", tvalid, 0);
        idle_cycle();
        chk("t1_first", {tvalid, tlast, tdata}, {2'b10, 32'd100});
        run_until_done(1'b0, cyc);
        chk("t1_cycles", cyc, 4);
        chk("t1_err", err, 0);
        idle_cycle();

        // Random back-pressure.
        do_start(32'd10, 32'd8, 8);
        run_until_done(1'b1, cyc);
        chk("t2_err", err, 0);
        tready = 1'b1;
        idle_cycle();

        // Clamped at the top of memory.
        do_start(LIMIT - 32'd2, 32'd5, 2);
        run_until_done(1'b0, cyc);
        chk("t3_err", err, 1);
        idle_cycle();

        // Out-of-range start and zero length complete immediately.
        do_start(LIMIT, 32'd3, 0);
        chk("t4a_done", {done, err, busy}, 3'b110);
        idle_cycle();
        do_start(32'd0, 32'd0, 0);
        chk("t4b_done", {done, err, busy}, 3'b100);
        idle_cycle();

        // Start mid-transfer is ignored; start in the done cycle is ignored.
        do_start(32'd20, 32'd6, 6);
        idle_cycle();
        start      = 1'b1;
        start_addr = 32'd50;
        length     = 32'd3;
        idle_cycle();
        start = 1'b0;
        run_until_done(1'b0, cyc);
        chk("t5_err", err, 0);
        start      = 1'b1;
        start_addr = 32'd70;
        length     = 32'd1;
        idle_cycle();
        chk("t5_ignored", busy, 0);
        do_start(32'd30, 32'd2, 2);
        chk("t5_accept", busy, 1);
        run_until_done(1'b0, cyc);
        idle_cycle();

        // Reset mid-transfer with the stream stalled.
        b0 = beats;
        do_start(32'd0, 32'd16, 16);
        cyc = 0;
        while ((beats - b0) < 3 && cyc < 50) begin
            idle_cycle();
            cyc++;
        end
        tready = 1'b0;
        chk("t6_three_beats", beats - b0, 3);
        repeat (4) idle_cycle();
        rst = 1'b1;
        rd_q.delete();
        exp_q.delete();
        idle_cycle();
        rst = 1'b0;
        chk("t6_after_rst", {tvalid, busy, rd_en, done}, 0);
        tready = 1'b1;
        do_start(32'd40, 32'd2, 2);
        run_until_done(1'b0, cyc);
        chk("t6_err", err, 0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
